// File: rtl/cacheline_mem_arbiter_if.sv
// cacheline_mem_arbiter_if: I-cache, D-cache and memory-side signals of the line arbiter.
// slave is the arbiter's view; master is the view of the caches and memory around it.
interface cacheline_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;
   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
   );
   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter: shares one line-wide memory port between I-cache and D-cache misses.
// Fixed D-over-I priority by default; define ARB_ROUND_ROBIN_EN to alternate on ties.
module cacheline_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input logic clk,
   input logic reset,
   cacheline_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_line;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_i_resp;
   logic              r_d_resp;
   logic              w_d_req;
   logic              w_req;
   logic              w_grant_d;
   logic              w_d_wr;
   assign w_d_req = bus.d_read | bus.d_write;
   assign w_req   = w_d_req | bus.i_read;
   assign w_d_wr  = w_grant_d & bus.d_write;
`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_d;
   assign w_grant_d = w_d_req & (~bus.i_read | ~r_last_d);
   always_ff @(posedge clk)
      if (reset) r_last_d <= 1'b0;
      else if (r_state == IDLE && w_req) r_last_d <= w_grant_d;
`else
   assign w_grant_d = w_d_req;
`endif
   // The strobes themselves hold the latched op, so memory is isolated from requester inputs.
   always_ff @(posedge clk)
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_line      <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_i_resp    <= 1'b0;
         r_d_resp    <= 1'b0;
      end else begin
         case (r_state)
            IDLE:
               if (w_req) begin
                  r_state     <= w_grant_d ? SERVE_D : SERVE_I;
                  r_addr      <= w_grant_d ? bus.d_addr : bus.i_addr;
                  r_wdata     <= w_d_wr ? bus.d_wdata : r_wdata;
                  r_mem_read  <= ~w_d_wr;
                  r_mem_write <= w_d_wr;
               end
            SERVE_I, SERVE_D:
               if (bus.mem_resp) begin
                  r_state     <= DONE;
                  r_line      <= r_mem_write ? r_line : bus.mem_rdata;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_i_resp    <= r_state == SERVE_I;
                  r_d_resp    <= r_state == SERVE_D;
               end
            DONE: begin
               r_state  <= IDLE;
               r_i_resp <= 1'b0;
               r_d_resp <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   assign bus.i_rdata   = r_line;
   assign bus.d_rdata   = r_line;
   assign bus.i_resp    = r_i_resp;
   assign bus.d_resp    = r_d_resp;
   assign bus.mem_read  = r_mem_read;
   assign bus.mem_write = r_mem_write;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// tb_cacheline_mem_arbiter: scenario tasks plus a randomized run against a grant-order model.
// The model tracks pending requesters and predicts each grant from the arbitration rule.
module tb_cacheline_mem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   rr_last_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   cacheline_mem_arbiter_if bus ();
   cacheline_mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rnd_line();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Memory + requester behaviour for one granted transaction.
   task automatic run_txn(input string name, input bit exp_d, input bit exp_w,
                          input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                          input int lat, input logic [255:0] rdata, input bit drop);
      int n = 0;
      while (!(bus.mem_read || bus.mem_write) && n < 12) begin
         tick();
         n++;
      end
      checks++;
      if (!(bus.mem_read || bus.mem_write)) begin
         failures++;
         $display("FAIL %s strobe timeout: got none, required a mem strobe", name);
         return;
      end
      checks++;
      if (bus.mem_addr !== exp_addr || bus.mem_write !== exp_w || bus.mem_read !== !exp_w) begin
         failures++;
         $display("FAIL %s request: got addr=%h rd=%b wr=%b, required addr=%h rd=%b wr=%b",
                  name, bus.mem_addr, bus.mem_read, bus.mem_write, exp_addr, !exp_w, exp_w);
      end
      if (exp_w) begin
         checks++;
         if (bus.mem_wdata !== exp_wdata) begin
            failures++;
            $display("FAIL %s wdata: got %h, required %h", name, bus.mem_wdata, exp_wdata);
         end
      end
      for (int j = 0; j < lat; j++) begin
         tick();
         checks++;
         if (bus.mem_read !== !exp_w || bus.mem_write !== exp_w || bus.i_resp || bus.d_resp) begin
            failures++;
            $display("FAIL %s hold cycle %0d: got rd=%b wr=%b iresp=%b dresp=%b, required rd=%b wr=%b no resp",
                     name, j, bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp, !exp_w, exp_w);
         end
      end
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = rdata;
      tick();
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = rnd_line();
      checks++;
      if (bus.d_resp !== exp_d || bus.i_resp !== !exp_d || bus.mem_read || bus.mem_write) begin
         failures++;
         $display("FAIL %s resp: got iresp=%b dresp=%b rd=%b wr=%b, required iresp=%b dresp=%b strobes 0",
                  name, bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write, !exp_d, exp_d);
      end
      if (!exp_w) begin
         checks++;
         if ((exp_d ? bus.d_rdata : bus.i_rdata) !== rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h, required %h", name,
                     exp_d ? bus.d_rdata : bus.i_rdata, rdata);
         end
      end
      if (drop) begin
         if (exp_d) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
         end else bus.i_read = 1'b0;
      end
      rr_last_d = exp_d;
      tick();
      checks++;
      if (bus.i_resp || bus.d_resp) begin
         failures++;
         $display("FAIL %s resp width: got iresp=%b dresp=%b after one cycle, required 0 0",
                  name, bus.i_resp, bus.d_resp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_0040;
      tick();
      tick();
      checks++;
      if (bus.mem_read || bus.mem_write || bus.i_resp || bus.d_resp || bus.mem_addr !== 32'h0 ||
          bus.mem_wdata !== 256'h0 || bus.i_rdata !== 256'h0 || bus.d_rdata !== 256'h0) begin
         failures++;
         $display("FAIL reset_outputs: got rd=%b wr=%b iresp=%b dresp=%b addr=%h, required all 0",
                  bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp, bus.mem_addr);
      end
      reset = 1'b0;
      rr_last_d = 1'b0;
      checks++;
      if (bus.mem_read !== 1'b0) begin
         failures++;
         $display("FAIL reset_arb_cycle: got mem_read=%b, required 0", bus.mem_read);
      end
      tick();
      checks++;
      if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_0040) begin
         failures++;
         $display("FAIL reset_first_strobe: got rd=%b addr=%h, required 1 00000040",
                  bus.mem_read, bus.mem_addr);
      end
      run_txn("reset_first_txn", 1'b0, 1'b0, 32'h0000_0040, 256'h0, 1, rnd_line(), 1'b1);
   endtask

   task automatic test_i_read();
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_0100;
      run_txn("i_read", 1'b0, 1'b0, 32'h0000_0100, 256'h0, 2, {32{8'hA5}}, 1'b1);
   endtask

   task automatic test_d_write();
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h8000_0040;
      bus.d_wdata = 256'h1234;
      run_txn("d_write", 1'b1, 1'b1, 32'h8000_0040, 256'h1234, 3, rnd_line(), 1'b1);
   endtask

   task automatic test_tie();
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_0100;
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_0200;
      run_txn("tie_first_d", 1'b1, 1'b0, 32'h0000_0200, 256'h0, 1, rnd_line(), 1'b1);
      run_txn("tie_then_i", 1'b0, 1'b0, 32'h0000_0100, 256'h0, 0, rnd_line(), 1'b1);
   endtask

   task automatic test_held_both();
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_1000;
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_2000;
      for (int t = 0; t < 4; t++) begin
         bit g = RR ? (t % 2 == 0) : 1'b1;
         run_txn($sformatf("held_both_%0d", t), g, 1'b0, g ? 32'h0000_2000 : 32'h0000_1000,
                 256'h0, t % 3, rnd_line(), t == 3);
      end
      bus.i_read = 1'b0;
      bus.d_read = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_late_request();
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_3000;
      tick();
      tick();
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_4000;
      run_txn("late_d", 1'b1, 1'b0, 32'h0000_3000, 256'h0, 2, rnd_line(), 1'b1);
      run_txn("late_i", 1'b0, 1'b0, 32'h0000_4000, 256'h0, 1, rnd_line(), 1'b1);
   endtask

   task automatic test_reset_mid();
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_5000;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.d_read = 1'b0;
      rr_last_d = 1'b0;
      checks++;
      if (bus.mem_read || bus.mem_write || bus.d_resp || bus.i_resp) begin
         failures++;
         $display("FAIL reset_mid_idle: got rd=%b wr=%b dresp=%b iresp=%b, required all 0",
                  bus.mem_read, bus.mem_write, bus.d_resp, bus.i_resp);
      end
      bus.mem_resp = 1'b1;
      tick();
      bus.mem_resp = 1'b0;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (bus.mem_read || bus.mem_write || bus.d_resp || bus.i_resp) begin
            failures++;
            $display("FAIL reset_mid_stray_resp cycle %0d: got rd=%b wr=%b dresp=%b iresp=%b, required all 0",
                     j, bus.mem_read, bus.mem_write, bus.d_resp, bus.i_resp);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         bit i_p = $urandom_range(0, 1);
         bit d_p = $urandom_range(0, 1);
         int dop = $urandom_range(0, 2);
         logic [31:0] ia = $urandom() & 32'hFFFF_FFE0;
         logic [31:0] da = $urandom() & 32'hFFFF_FFE0;
         logic [255:0] wd = rnd_line();
         if (!i_p && !d_p) i_p = 1'b1;
         bus.i_read  = i_p;
         bus.i_addr  = ia;
         bus.d_read  = d_p && dop != 1;
         bus.d_write = d_p && dop != 0;
         bus.d_addr  = da;
         bus.d_wdata = wd;
         while (i_p || d_p) begin
            bit g = d_p && (!i_p || !RR || !rr_last_d);
            bit w = g && dop != 0;
            run_txn($sformatf("random_%0d_%s", it, g ? "d" : "i"), g, w, g ? da : ia, wd,
                    $urandom_range(0, 4), rnd_line(), 1'b1);
            if (g) d_p = 1'b0;
            else i_p = 1'b0;
         end
      end
   endtask

   initial begin
      bus.i_read = 1'b0;
      bus.i_addr = '0;
      bus.d_read = 1'b0;
      bus.d_write = 1'b0;
      bus.d_addr = '0;
      bus.d_wdata = '0;
      bus.mem_rdata = '0;
      bus.mem_resp = 1'b0;
      test_reset();
      test_i_read();
      test_d_write();
      test_tie();
      test_held_both();
      test_late_request();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   always @(negedge clk) begin
      if (!reset && bus.mem_read && bus.mem_write) begin
         failures++;
         $display("FAIL strobe_exclusive: got rd=1 wr=1, required at most one");
      end
   end
endmodule
